// File: rtl/serial_parity_tx.sv
// Parallel-to-serial frame transmitter: DATA_W payload bits LSB first, one parity bit,
// then GAP_CYC idle cycles. sout/frame/last are registered.
module serial_parity_tx #(
    parameter int DATA_W  = 8,
    parameter int ODD     = 1,
    parameter int GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              sout,
    output logic              frame,
    output logic              last
);
    // state | meaning
    // IDLE  | waiting for a payload, ready=1
    // SHIFT | data bits on sout, LSB first
    // PAR   | parity bit on sout (ready=1 when GAP_CYC=0)
    // GAP   | inter-frame idle, GAP_CYC cycles
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-2:0] shreg;
    logic [CW-1:0]     cnt;
    logic [3:0]        gcnt;
    logic              par;
    logic              accept;
    logic              bit_last;
    logic              sout_d;
    logic              frame_d;
    logic              last_d;

    assign ready    = (state == IDLE) || (GAP_CYC == 0 && state == PAR);
    assign accept   = valid && ready;
    assign bit_last = (cnt == CW'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = SHIFT;
            SHIFT: if (bit_last) state_nxt = PAR;
            PAR: begin
                if (GAP_CYC > 0)  state_nxt = GAP;
                else if (accept)  state_nxt = SHIFT;
                else              state_nxt = IDLE;
            end
            GAP:   if (gcnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Values computed here appear on the pins one cycle later, so an accept
    // already presents data bit 0 and the final SHIFT cycle presents parity.
    always_comb begin
        sout_d  = 1'b0;
        frame_d = 1'b0;
        last_d  = 1'b0;
        if (accept) begin
            sout_d  = data_in[0];
            frame_d = 1'b1;
        end else if (state == SHIFT) begin
            frame_d = 1'b1;
            if (bit_last) begin
                sout_d = par;
                last_d = 1'b1;
            end else begin
                sout_d = shreg[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            gcnt  <= '0;
            par   <= 1'b0;
            sout  <= 1'b0;
            frame <= 1'b0;
            last  <= 1'b0;
        end else begin
            sout  <= sout_d;
            frame <= frame_d;
            last  <= last_d;
            if (accept) begin
                shreg <= data_in[DATA_W-1:1];
                cnt   <= '0;
                par   <= (^data_in) ^ 1'(ODD);
            end else if (state == SHIFT && !bit_last) begin
                shreg <= shreg >> 1;
                cnt   <= cnt + CW'(1);
            end
            if (state == PAR)
                gcnt <= 4'(GAP_CYC - 1);
            else if (state == GAP && gcnt != 4'd0)
                gcnt <= gcnt - 4'd1;
        end
    end
endmodule
